// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle fetch / execute / write-back control FSM.
// Fetches one instruction, holds it for the datapath, retires it, and stops on ebreak or traps.
module exec_sequencer #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned CNT_W    = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req_valid,
    output logic [63:0]      imem_req_addr,
    input  logic             imem_req_ready,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_inst,
    output logic [31:0]      inst_q,
    output logic             exec_en,
    input  logic             exec_done,
    input  logic             exec_redirect,
    input  logic [63:0]      exec_target,
    output logic             rf_wen,
    output logic [63:0]      pc,
    output logic [CNT_W-1:0] retired,
    output logic             halted,
    output logic             trap,
    output logic [1:0]       trap_cause
);
    localparam int unsigned      TMR_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(TIMEOUT - 1);
    localparam logic [31:0]      INST_NOP    = 32'h0000_0013;
    localparam logic [31:0]      INST_EBREAK = 32'h0010_0073;
    localparam logic [1:0]       CAUSE_NONE    = 2'd0;
    localparam logic [1:0]       CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0]       CAUSE_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_WAIT_RSP,
        ST_EXEC,
        ST_WB,
        ST_HALT,
        ST_TRAP
    } state_e;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             redir_q, redir_d;
    logic [63:0]      target_q, target_d;
    logic [31:0]      inst_d;
    logic [63:0]      pc_d;
    logic [CNT_W-1:0] retired_d;
    logic [1:0]       cause_d;

    assign imem_req_addr = pc;

    // Next-state and datapath-register update logic.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        redir_d   = redir_q;
        target_d  = target_q;
        inst_d    = inst_q;
        pc_d      = pc;
        retired_d = retired;
        cause_d   = trap_cause;

        case (state_q)
            ST_FETCH: begin
                if (imem_req_valid && imem_req_ready) begin
                    state_d = ST_WAIT_RSP;
                    timer_d = '0;
                end
            end
            ST_WAIT_RSP: begin
                // A response in the last allowed cycle beats the timeout.
                if (imem_rsp_valid) begin
                    inst_d = imem_rsp_inst;
                    if (imem_rsp_inst == INST_EBREAK) begin
                        state_d = ST_HALT;
                    end else if (imem_rsp_inst[1:0] != 2'b11) begin
                        state_d = ST_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end else if (timer_q == TMR_LAST) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_EXEC: begin
                if (exec_done) begin
                    state_d  = ST_WB;
                    redir_d  = exec_redirect;
                    target_d = exec_target & ~64'h1;
                end
            end
            ST_WB: begin
                state_d   = ST_FETCH;
                retired_d = retired + CNT_W'(1);
                pc_d      = redir_q ? target_q : pc + 64'd4;
            end
            ST_HALT, ST_TRAP: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State register with Moore outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_FETCH;
            timer_q        <= '0;
            redir_q        <= 1'b0;
            target_q       <= '0;
            inst_q         <= INST_NOP;
            pc             <= RESET_PC;
            retired        <= '0;
            imem_req_valid <= 1'b0;
            exec_en        <= 1'b0;
            rf_wen         <= 1'b0;
            halted         <= 1'b0;
            trap           <= 1'b0;
            trap_cause     <= CAUSE_NONE;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            redir_q        <= redir_d;
            target_q       <= target_d;
            inst_q         <= inst_d;
            pc             <= pc_d;
            retired        <= retired_d;
            imem_req_valid <= (state_d == ST_FETCH);
            exec_en        <= (state_d == ST_EXEC);
            rf_wen         <= (state_d == ST_WB);
            halted         <= (state_d == ST_HALT);
            trap           <= (state_d == ST_TRAP);
            trap_cause     <= cause_d;
        end
    end
endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: randomized fetch/execute traffic against a transaction-level PC/retire model.
// The driver pushes expected fetches, write-backs and stop events; a negedge monitor checks them.
module tb_exec_sequencer;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam int          TIMEOUT  = 16;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam int M_NORMAL  = 0;
    localparam int M_TIMEOUT = 2;
    localparam int M_RESET   = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_inst = 32'h0;
    logic [31:0] inst_q;
    logic        exec_en;
    logic        exec_done = 1'b0;
    logic        exec_redirect = 1'b0;
    logic [63:0] exec_target = 64'h0;
    logic        rf_wen;
    logic [63:0] pc;
    logic [63:0] retired;
    logic        halted;
    logic        trap;
    logic [1:0]  trap_cause;

    exec_sequencer #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT), .CNT_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_inst(imem_rsp_inst),
        .inst_q(inst_q), .exec_en(exec_en), .exec_done(exec_done),
        .exec_redirect(exec_redirect), .exec_target(exec_target),
        .rf_wen(rf_wen), .pc(pc), .retired(retired),
        .halted(halted), .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] inst;
        logic [63:0] ret;
        int          ecyc;
        int          lat;
    } wb_t;

    typedef struct {
        logic        halted;
        logic        trap;
        logic [1:0]  cause;
        logic [63:0] pc;
        logic [63:0] ret;
        logic        chk_inst;
        logic [31:0] inst;
        int          wait_cyc;
    } end_t;

    logic [63:0] addr_q[$];
    wb_t         wb_q[$];
    end_t        end_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] m_pc = RESET_PC;
    logic [63:0] m_ret = 64'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows a fetch, a write-back or a stop.
    int   cyc = 0;
    int   hs_cyc = 0;
    int   ecnt = 0;
    bit   term_seen = 1'b0;
    wb_t  mon_w;
    end_t mon_e;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            ecnt      = 0;
            term_seen = 1'b0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                hs_cyc = cyc;
                chk("fetch_pending", 64'(addr_q.size()), 64'd1);
                if (addr_q.size() > 0) chk("fetch_addr", imem_req_addr, addr_q.pop_front());
            end
            if (exec_en) ecnt++;
            if (rf_wen) begin
                chk("wb_pending", 64'(wb_q.size()), 64'd1);
                if (wb_q.size() > 0) begin
                    mon_w = wb_q.pop_front();
                    chk("wb_pc", pc, mon_w.addr);
                    chk("wb_inst", 64'(inst_q), 64'(mon_w.inst));
                    chk("wb_retired", retired, mon_w.ret);
                    chk("exec_en_cycles", 64'(ecnt), 64'(mon_w.ecyc));
                    chk("insn_latency", 64'(cyc - hs_cyc), 64'(mon_w.lat));
                end
                ecnt = 0;
            end
            if ((halted || trap) && !term_seen) begin
                term_seen = 1'b1;
                chk("end_pending", 64'(end_q.size()), 64'd1);
                if (end_q.size() > 0) begin
                    mon_e = end_q.pop_front();
                    chk("end_halted", 64'(halted), 64'(mon_e.halted));
                    chk("end_trap", 64'(trap), 64'(mon_e.trap));
                    chk("end_cause", 64'(trap_cause), 64'(mon_e.cause));
                    chk("end_pc", pc, mon_e.pc);
                    chk("end_retired", retired, mon_e.ret);
                    if (mon_e.chk_inst) chk("end_inst", 64'(inst_q), 64'(mon_e.inst));
                    if (mon_e.wait_cyc > 0) chk("timeout_latency", 64'(cyc - hs_cyc), 64'(mon_e.wait_cyc));
                end
            end else if (term_seen) begin
                chk("terminal_quiet", 64'({imem_req_valid, exec_en, rf_wen}), 64'd0);
                chk("terminal_pc", pc, mon_e.pc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom();
        r[1:0] = 2'b11;
        if (r == EBREAK) r = NOP;
        return r;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_async_ctrl", 64'({imem_req_valid, exec_en, rf_wen, halted, trap, trap_cause}), 64'd0);
        chk("rst_async_pc", pc, RESET_PC);
        chk("rst_async_retired", retired, 64'd0);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        exec_done      = 1'b0;
        exec_redirect  = 1'b0;
        chk("queues_drained", 64'(addr_q.size() + wb_q.size() + end_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_inst_q", 64'(inst_q), 64'(NOP));
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        m_pc  = RESET_PC;
        m_ret = 64'd0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("req_valid_after_release", 64'(imem_req_valid), 64'd1);
    endtask

    task automatic run_insn(input logic [31:0] inst, input int d_ready, input int d_rsp, input int d_exec,
                            input logic redir, input logic [63:0] target, input int mode);
        int n;
        addr_q.push_back(m_pc);
        n = 0;
        while (!imem_req_valid && n < 50) begin
            step();
            n++;
        end
        if (!imem_req_valid) begin
            chk("req_valid_seen", 64'(imem_req_valid), 64'd1);
            return;
        end
        repeat (d_ready) begin
            imem_rsp_valid = 1'($urandom_range(0, 1));
            imem_rsp_inst  = 32'h0;
            step();
        end
        if (d_ready > 0) chk("req_held", 64'(imem_req_valid), 64'd1);
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;

        if (mode == M_TIMEOUT) begin
            end_q.push_back('{1'b0, 1'b1, 2'd2, m_pc, m_ret, 1'b0, 32'h0, TIMEOUT + 1});
            repeat (TIMEOUT + 4) begin
                exec_done = 1'($urandom_range(0, 1));
                step();
            end
            exec_done = 1'b0;
            return;
        end

        repeat (d_rsp) begin
            exec_done = 1'($urandom_range(0, 1));
            step();
        end
        exec_done      = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_inst  = inst;
        if (inst == EBREAK) begin
            end_q.push_back('{1'b1, 1'b0, 2'd0, m_pc, m_ret, 1'b1, inst, 0});
        end else if (inst[1:0] != 2'b11) begin
            end_q.push_back('{1'b0, 1'b1, 2'd1, m_pc, m_ret, 1'b1, inst, 0});
        end else if (mode == M_NORMAL) begin
            wb_q.push_back('{m_pc, inst, m_ret, d_exec + 1, d_rsp + d_exec + 3});
            m_ret = m_ret + 64'd1;
            m_pc  = redir ? (target & ~64'h1) : m_pc + 64'd4;
        end
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_inst  = $urandom();

        if (inst == EBREAK || inst[1:0] != 2'b11) begin
            imem_req_ready = 1'b1;
            repeat (20) begin
                imem_rsp_valid = 1'($urandom_range(0, 1));
                exec_done      = 1'($urandom_range(0, 1));
                step();
            end
            imem_req_ready = 1'b0;
            imem_rsp_valid = 1'b0;
            exec_done      = 1'b0;
            return;
        end

        if (mode == M_RESET) begin
            repeat (2) step();
            chk("exec_en_before_abort", 64'(exec_en), 64'd1);
            #2 rst_n = 1'b0;
            #1;
            chk("abort_ctrl", 64'({exec_en, rf_wen, imem_req_valid}), 64'd0);
            chk("abort_retired", retired, 64'd0);
            chk("abort_pc", pc, RESET_PC);
            do_reset();
            return;
        end

        repeat (d_exec) begin
            imem_rsp_valid = 1'($urandom_range(0, 1));
            imem_rsp_inst  = 32'h0;
            exec_redirect  = 1'($urandom_range(0, 1));
            exec_target    = {$urandom(), $urandom()};
            step();
        end
        imem_rsp_valid = 1'b0;
        exec_done      = 1'b1;
        exec_redirect  = redir;
        exec_target    = target;
        step();
        exec_done      = 1'b0;
        exec_redirect  = ~redir;
        exec_target    = {$urandom(), $urandom()};
    endtask

    task automatic run_random(input int count, input int max_ready);
        for (int i = 0; i < count; i++) begin
            logic        redir;
            logic [63:0] tgt;
            redir = ($urandom_range(0, 3) == 0);
            tgt   = {$urandom(), $urandom()};
            run_insn(rand_inst(), int'($urandom_range(0, max_ready)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 4)), redir, tgt, M_NORMAL);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        #1;
        do_reset();
        run_insn(32'h0050_0093, 0, 0, 0, 1'b0, 64'h0, M_NORMAL);
        for (int i = 0; i < 3; i++) run_insn(32'h0050_0093, 3, 0, 0, 1'b0, 64'h0, M_NORMAL);
        run_insn(rand_inst(), 0, 0, 5, 1'b1, 64'h0000_0000_8000_0101, M_NORMAL);
        run_insn(rand_inst(), 0, 0, 0, 1'b0, 64'h0, M_NORMAL);
        run_random(8, 3);
        run_insn(EBREAK, 1, 1, 0, 1'b0, 64'h0, M_NORMAL);

        do_reset();
        run_random(2, 2);
        run_insn(EBREAK, 0, 0, 0, 1'b0, 64'h0, M_NORMAL);

        do_reset();
        run_random(3, 2);
        run_insn(32'h0000_0001, 0, 2, 0, 1'b0, 64'h0, M_NORMAL);

        do_reset();
        run_random(3, 2);
        run_insn(rand_inst(), 0, 0, 0, 1'b0, 64'h0, M_TIMEOUT);

        do_reset();
        run_insn(rand_inst(), 1, TIMEOUT - 1, 1, 1'b0, 64'h0, M_NORMAL);
        run_insn(EBREAK, 0, 0, 0, 1'b0, 64'h0, M_NORMAL);

        do_reset();
        run_random(2, 1);
        run_insn(rand_inst(), 0, 1, 0, 1'b0, 64'h0, M_RESET);
        run_random(2, 2);
        run_insn(EBREAK, 0, 0, 0, 1'b0, 64'h0, M_NORMAL);

        chk("final_queues_drained", 64'(addr_q.size() + wb_q.size() + end_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Multi-cycle control FSM that sequences the decode/execute datapath: fetches one instruction over an instruction-memory handshake and holds it stable for the datapath.
- Gates execution and register-file write-back, updates the PC, counts retired instructions and halts on ebreak, illegal encodings or fetch timeout.
- Sits between the instruction memory port and decode_exec; decode_exec receives inst_q, and its register write is qualified by rf_wen.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.
- TIMEOUT, 16, max cycles in WAIT_RSP before fetch-timeout trap (>=1).
- CNT_W, 64, width of retire counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  64  fetch address (= pc).
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  instruction data valid.
- imem_rsp_inst  in  32  fetched instruction.
- inst_q  out  32  latched instruction driven to datapath.
- exec_en  out  1  datapath execute enable (high throughout EXEC).
- exec_done  in  1  datapath result ready (sampled in EXEC).
- exec_redirect  in  1  next PC is exec_target (sampled with exec_done).
- exec_target  in  64  redirect target.
- rf_wen  out  1  register-file write enable, one-cycle pulse in WB.
- pc  out  64  current instruction PC.
- retired  out  CNT_W  retired instruction count.
- halted  out  1  ebreak reached.
- trap  out  1  error stop.
- trap_cause  out  2  0 none, 1 illegal (inst[1:0]!=2'b11), 2 fetch timeout.

Behaviour:
- Reset (async, rst_n=0): state=FETCH, pc=RESET_PC, inst_q=32'h0000_0013 (nop), retired=0, timer=0. All of imem_req_valid, exec_en, rf_wen, halted, trap, trap_cause are 0 while rst_n=0; imem_req_valid rises the first cycle after release.
- States: FETCH, WAIT_RSP, EXEC, WB, HALT, TRAP. Outputs are registered/Moore; imem_req_valid=1 only in FETCH, exec_en=1 only in EXEC, rf_wen=1 only in WB.
- FETCH: imem_req_addr=pc held stable. On imem_req_valid&&imem_req_ready -> WAIT_RSP, timer=0. Request is never withdrawn while unaccepted.
- WAIT_RSP: on imem_rsp_valid, inst_q<=imem_rsp_inst:
  - imem_rsp_inst==32'h0010_0073 (ebreak) -> HALT, halted=1.
  - imem_rsp_inst[1:0]!=2'b11 -> TRAP, cause=1.
  - otherwise -> EXEC.
  - Without a response, timer increments each cycle; when timer reaches TIMEOUT-1 with no response -> TRAP, cause=2. A response arriving in that same cycle wins (no trap).
- EXEC: exec_en=1, inst_q stable. If exec_done in the state's first cycle -> WB (minimum 1 cycle). Otherwise remain indefinitely; there is no timeout in EXEC. exec_redirect/exec_target are latched only in the exec_done cycle.
- WB: rf_wen=1 for exactly one cycle; retired+=1, wrapping modulo 2^CNT_W.
  - pc<=latched_redirect ? {exec_target[63:1],1'b0} : pc+4 (64-bit, wraps).
  - -> FETCH.
- Minimum instruction latency: FETCH(1) + WAIT_RSP(1) + EXEC(1) + WB(1) = 4 cycles, provided ready and rsp_valid arrive the same cycle they are first sampled.
- HALT/TRAP are terminal until reset:
  - No requests, exec_en=0, rf_wen=0.
  - pc holds the offending instruction's address; retired does not count ebreak or the trapping instruction.
- imem_rsp_valid outside WAIT_RSP is ignored. exec_done outside EXEC is ignored.
- Reset asserted mid-instruction aborts immediately: no rf_wen pulse, retired unchanged before being cleared, pending response discarded.

Test Plan:
- Reset release, memory always ready, rsp 1 cycle later with addi x1,x0,5 (32'h0050_0093), exec_done immediate -> req addr 0x8000_0000; rf_wen pulses on cycle 4; pc=0x8000_0004; retired=1.
- Three sequential addi, imem_req_ready delayed 3 cycles each -> imem_req_valid/addr held stable; addresses 0x...0, 0x...4, 0x...8 in order; retired=3.
- exec_redirect=1, exec_target=0x8000_0101 with exec_done -> next fetch addr 0x8000_0100; exec_done held low 5 cycles -> exec_en high for 6 cycles and a single rf_wen pulse.
- Fetch of 32'h0010_0073 after 2 retired -> halted=1, retired=2, pc stays on the ebreak address, no further imem_req_valid over 20 cycles.
- Response 32'h0000_0001 -> trap=1, trap_cause=1. Separately, no response with TIMEOUT=16 -> trap_cause=2 exactly 16 cycles into WAIT_RSP; a response on cycle 16 -> no trap.
- rst_n pulsed low while in EXEC -> outputs clear asynchronously, no rf_wen, retired=0, pc=RESET_PC; fetch restarts the cycle after release.
